ctrl_fsm: RTL and testbench

Multi-cycle main control unit for the RV32 datapath. It latches the fetched instruction, decodes it, and sequences the datapath through the fetch/decode/execute/memory/write-back phases. It drives every datapath control input: PC select and enable, ALU source and op, RAM read/write, write-back select, register write, and immediate format. It uses the ALU status flags to resolve branches, and sits beside the datapath top as its sole controller.

---
 rtl/ctrl_pkg.sv | 104 ++++++++++
 rtl/ctrl_if.sv | 28 ++
 rtl/ctrl_decode.sv | 56 +++++
 rtl/ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32 multi-cycle controller: FSM states,
// instruction classes, opcode/funct3 constants, ALU and immediate-format codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU_R  = 3'd1,
        CLS_ALU_I  = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   aluop;
        logic         alusrc;
        logic [1:0]   immgen;
        logic         illegal;
    } decode_t;

    // alt selects SUB (funct3 0) or SRA (funct3 5) when the instruction allows it
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic n, input logic v);
        logic t;
        case (f3)
            F3_BEQ:  t = z;
            F3_BNE:  t = !z;
            F3_BLT:  t = n ^ v;
            F3_BGE:  t = !(n ^ v);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ctrl_if.sv
// Control bus between the RV32 datapath and its controller; master is the
// controller, slave is the datapath.
interface ctrl_if;

    logic [31:0] instr;
    logic [3:0]  status;
    logic        run;
    logic        pc_en;
    logic        pcsrc;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        mrw;
    logic        wb;
    logic        regrw;
    logic [1:0]  immgen_ctrl;
    logic        halt;

    modport master (
        input  instr, status, run,
        output pc_en, pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl, halt
    );

    modport slave (
        output instr, status, run,
        input  pc_en, pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl, halt
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the latched instruction and
// derives its ALU op, operand source, immediate format and legality.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output decode_t    dec
);

    always_comb begin
        dec.cls     = CLS_NONE;
        dec.aluop   = ALU_ADD;
        dec.alusrc  = 1'b0;
        dec.immgen  = IMM_I;
        dec.illegal = 1'b1;
        case (opcode)
            OP_R: begin
                dec.cls     = CLS_ALU_R;
                dec.aluop   = alu_from_f3(funct3, funct7[5]);
                dec.illegal = !((funct7 == F7_BASE) ||
                                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
            end
            // Only the shift-right immediate uses funct7; ADDI never becomes SUB
            OP_I: begin
                dec.cls     = CLS_ALU_I;
                dec.alusrc  = 1'b1;
                dec.aluop   = alu_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
                dec.illegal = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                              ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OP_LOAD: begin
                dec.cls     = CLS_LOAD;
                dec.alusrc  = 1'b1;
                dec.immgen  = IMM_I;
                dec.illegal = (funct3 != F3_LW);
            end
            OP_STORE: begin
                dec.cls     = CLS_STORE;
                dec.alusrc  = 1'b1;
                dec.immgen  = IMM_S;
                dec.illegal = (funct3 != F3_SW);
            end
            OP_BRANCH: begin
                dec.cls     = CLS_BRANCH;
                dec.aluop   = ALU_SUB;
                dec.immgen  = IMM_B;
                dec.illegal = !((funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
                                (funct3 == F3_BLT) || (funct3 == F3_BGE));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32 main control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define CTRL_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
`ifdef CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    ctrl_if.master    bus
);

    state_t      state;
    logic [31:0] ir;
    decode_t     dec;

    logic       pc_en_q;
    logic       alusrc_q;
    logic [3:0] aluop_q;
    logic       mrw_q;
    logic       wb_q;
    logic       regrw_q;
    logic [1:0] immgen_q;
    logic       halt_q;

    logic unused_fields;
    assign unused_fields = ^{ir[24:15], ir[11:7], bus.status[STAT_C]};

    ctrl_decode u_decode (
        .opcode (ir[6:0]),
        .funct3 (ir[14:12]),
        .funct7 (ir[31:25]),
        .dec    (dec)
    );

    // Strobes default low every cycle so each is a single-state pulse; the
    // datapath controls latched at EXEC entry persist until the return to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            ir       <= '0;
            pc_en_q  <= 1'b0;
            alusrc_q <= 1'b0;
            aluop_q  <= ALU_ADD;
            mrw_q    <= 1'b0;
            wb_q     <= 1'b0;
            regrw_q  <= 1'b0;
            immgen_q <= IMM_I;
            halt_q   <= 1'b0;
        end else begin
            pc_en_q <= 1'b0;
            mrw_q   <= 1'b0;
            wb_q    <= 1'b0;
            regrw_q <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (bus.run) begin
                        state <= ST_DECODE;
                        ir    <= bus.instr;
                    end
                end
                ST_DECODE: begin
                    if (dec.illegal) begin
                        state  <= ST_TRAP;
                        halt_q <= 1'b1;
                    end else begin
                        state    <= ST_EXEC;
                        aluop_q  <= dec.aluop;
                        alusrc_q <= dec.alusrc;
                        immgen_q <= dec.immgen;
                        pc_en_q  <= (dec.cls == CLS_BRANCH);
                    end
                end
                ST_EXEC: begin
                    case (dec.cls)
                        CLS_LOAD: state <= ST_MEM;
                        CLS_STORE: begin
                            state   <= ST_MEM;
                            mrw_q   <= 1'b1;
                            pc_en_q <= 1'b1;
                        end
                        CLS_BRANCH: begin
                            state    <= ST_FETCH;
                            aluop_q  <= ALU_ADD;
                            alusrc_q <= 1'b0;
                            immgen_q <= IMM_I;
                        end
                        default: begin
                            state   <= ST_WB;
                            regrw_q <= 1'b1;
                            wb_q    <= 1'b1;
                            pc_en_q <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dec.cls == CLS_LOAD) begin
                        state   <= ST_WB;
                        regrw_q <= 1'b1;
                        pc_en_q <= 1'b1;
                    end else begin
                        state    <= ST_FETCH;
                        aluop_q  <= ALU_ADD;
                        alusrc_q <= 1'b0;
                        immgen_q <= IMM_I;
                    end
                end
                ST_WB: begin
                    state    <= ST_FETCH;
                    aluop_q  <= ALU_ADD;
                    alusrc_q <= 1'b0;
                    immgen_q <= IMM_I;
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Flags are only valid during the branch EXEC cycle, so pcsrc is resolved live there
    assign bus.pcsrc = (state == ST_EXEC) && (dec.cls == CLS_BRANCH) &&
                       branch_taken(ir[14:12], bus.status[STAT_Z],
                                    bus.status[STAT_N], bus.status[STAT_V]);

    assign bus.pc_en       = pc_en_q;
    assign bus.alusrc      = alusrc_q;
    assign bus.aluop       = aluop_q;
    assign bus.mrw         = mrw_q;
    assign bus.wb          = wb_q;
    assign bus.regrw       = regrw_q;
    assign bus.immgen_ctrl = immgen_q;
    assign bus.halt        = halt_q;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != ST_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_en_q)          instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm: walks each instruction class
// cycle by cycle, plus trap, run-hold and mid-instruction reset.
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ctrl_if bus ();

`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CTRL_PERF_EN
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
`endif
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] instr, input logic [3:0] status,
                                  input logic run);
        bus.instr  = instr;
        bus.status = status;
        bus.run    = run;
    endtask

    // Expected vector: {state, pc_en, pcsrc, alusrc, aluop, mrw, wb, regrw, immgen, halt}
    task automatic check_output(input string tag, input state_t est, input logic e_pc_en,
                                input logic e_pcsrc, input logic e_alusrc,
                                input logic [3:0] e_aluop, input logic e_mrw, input logic e_wb,
                                input logic e_regrw, input logic [1:0] e_imm,
                                input logic e_halt);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {dut.state, bus.pc_en, bus.pcsrc, bus.alusrc, bus.aluop, bus.mrw,
               bus.wb, bus.regrw, bus.immgen_ctrl, bus.halt};
        exp = {est, e_pc_en, e_pcsrc, e_alusrc, e_aluop, e_mrw, e_wb, e_regrw, e_imm, e_halt};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input state_t est);
        check_output(tag, est, 0, 0, 0, ALU_ADD, 0, 0, 0, IMM_I, 0);
    endtask

    // Start an instruction from FETCH and drop run once it is in DECODE
    task automatic start_instr(input string tag, input logic [31:0] instr,
                               input logic [3:0] status);
        apply_stimulus(instr, status, 1'b1);
        step();
        check_idle({tag, "_decode"}, ST_DECODE);
        bus.run = 1'b0;
    endtask

    logic [31:0] alu_instr [4];
    logic [3:0]  alu_op    [4];
    logic        alu_src   [4];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        apply_stimulus(32'h0, 4'h0, 1'b0);
        alu_instr[0] = 32'h402081B3; alu_op[0] = ALU_SUB;  alu_src[0] = 1'b0;
        alu_instr[1] = 32'h4030D093; alu_op[1] = ALU_SRA;  alu_src[1] = 1'b1;
        alu_instr[2] = 32'h0020B1B3; alu_op[2] = ALU_SLTU; alu_src[2] = 1'b0;
        alu_instr[3] = 32'h0030D093; alu_op[3] = ALU_SRL;  alu_src[3] = 1'b1;

        step();
        step();
        check_idle("reset_state", ST_FETCH);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) step();
        check_idle("run_low_hold", ST_FETCH);

        start_instr("addi", 32'h00500093, 4'h0);
        step();
        check_output("addi_exec", ST_EXEC, 0, 0, 1, ALU_ADD, 0, 0, 0, IMM_I, 0);
        step();
        check_output("addi_wb", ST_WB, 1, 0, 1, ALU_ADD, 0, 1, 1, IMM_I, 0);
        step();
        check_idle("addi_fetch", ST_FETCH);
        step();
        check_idle("addi_run_low", ST_FETCH);

        start_instr("lw", 32'h00802283, 4'h0);
        step();
        check_output("lw_exec", ST_EXEC, 0, 0, 1, ALU_ADD, 0, 0, 0, IMM_I, 0);
        step();
        check_output("lw_mem", ST_MEM, 0, 0, 1, ALU_ADD, 0, 0, 0, IMM_I, 0);
        step();
        check_output("lw_wb", ST_WB, 1, 0, 1, ALU_ADD, 0, 0, 1, IMM_I, 0);
        step();
        check_idle("lw_fetch", ST_FETCH);

        start_instr("sw", 32'h00502623, 4'h0);
        step();
        check_output("sw_exec", ST_EXEC, 0, 0, 1, ALU_ADD, 0, 0, 0, IMM_S, 0);
        step();
        check_output("sw_mem", ST_MEM, 1, 0, 1, ALU_ADD, 1, 0, 0, IMM_S, 0);
        step();
        check_idle("sw_fetch", ST_FETCH);

        start_instr("beq_t", 32'h00000463, 4'b0001);
        step();
        check_output("beq_t_exec", ST_EXEC, 1, 1, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();
        check_idle("beq_t_fetch", ST_FETCH);

        start_instr("beq_nt", 32'h00000463, 4'b0000);
        step();
        check_output("beq_nt_exec", ST_EXEC, 1, 0, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        bus.status = 4'b0001;
        #1;
        check_output("beq_live_flag", ST_EXEC, 1, 1, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();
        check_idle("beq_nt_fetch", ST_FETCH);

        start_instr("bne", 32'h00001463, 4'b0001);
        step();
        check_output("bne_exec", ST_EXEC, 1, 0, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();
        start_instr("blt", 32'h00004463, 4'b0010);
        step();
        check_output("blt_exec", ST_EXEC, 1, 1, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();
        start_instr("bge_nt", 32'h00005463, 4'b0010);
        step();
        check_output("bge_nt_exec", ST_EXEC, 1, 0, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();
        start_instr("bge_t", 32'h00005463, 4'b1010);
        step();
        check_output("bge_t_exec", ST_EXEC, 1, 1, 0, ALU_SUB, 0, 0, 0, IMM_B, 0);
        step();

        for (int i = 0; i < 4; i++) begin
            start_instr("alu", alu_instr[i], 4'h0);
            step();
            check_output("alu_exec", ST_EXEC, 0, 0, alu_src[i], alu_op[i], 0, 0, 0, IMM_I, 0);
            step();
            check_output("alu_wb", ST_WB, 1, 0, alu_src[i], alu_op[i], 0, 1, 1, IMM_I, 0);
            step();
        end
        check_idle("alu_done", ST_FETCH);

        start_instr("bltu_illegal", 32'h00006463, 4'h0);
        step();
        check_output("bltu_trap", ST_TRAP, 0, 0, 0, ALU_ADD, 0, 0, 0, IMM_I, 1);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        check_idle("bltu_reset", ST_FETCH);

        start_instr("ones", 32'hFFFFFFFF, 4'hF);
        bus.run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_output("trap_hold", ST_TRAP, 0, 0, 0, ALU_ADD, 0, 0, 0, IMM_I, 1);
        end
        bus.run = 1'b0;
        reset = 1'b0;
        #1;
        check_idle("trap_reset", ST_FETCH);
        #2;
        reset = 1'b1;
        step();
        check_idle("trap_after_reset", ST_FETCH);

        start_instr("lw_rst", 32'h00802283, 4'h0);
        step();
        step();
        step();
        check_output("lw_rst_wb", ST_WB, 1, 0, 1, ALU_ADD, 0, 0, 1, IMM_I, 0);
        #2;
        reset = 1'b0;
        #1;
        check_idle("lw_rst_abort", ST_FETCH);
        #2;
        reset = 1'b1;
        step();
        check_idle("lw_rst_after", ST_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
